// File: rtl/mdu_unit_pkg.sv
// Shared multiply/divide definitions: MD_* opcode encodings (4-bit), the
// controller state type and opcode classification helpers. Imported by the
// MDU controller, its datapath core and the hazard unit.
package mdu_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } md_state_e;

  // Multi-cycle operations: these occupy the unit and raise busy.
  function automatic logic md_is_long(input logic [3:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Single-cycle HI/LO writes.
  function automatic logic md_is_mt(input logic [3:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

endpackage

// File: rtl/mdu_unit_md_core.sv
// md_core: purely combinational 64-bit multiply/divide result from the
// operands latched by the controller.
//   i_op      latched MD_* opcode
//   i_a/i_b   latched rs/rt operands
//   o_result  {hi,lo} value to commit
//   o_wr      1 when HI/LO should be written at completion (0 on divide by zero)
module md_core
  import mdu_unit_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_result,
  output logic        o_wr
);

  logic               w_div0;
  logic               w_ovf;
  logic [31:0]        w_b_safe;
  logic signed [63:0] w_sa;
  logic signed [63:0] w_sb;
  logic [63:0]        w_sprod;
  logic [63:0]        w_uprod;
  logic [31:0]        w_squot;
  logic [31:0]        w_srem;
  logic [31:0]        w_uquot;
  logic [31:0]        w_urem;

  assign w_div0 = (i_b == '0);
  assign w_ovf  = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

  // The divider never sees zero or the signed overflow pair: dividing by 1
  // instead yields the required 0x80000000 / 0 for the overflow case, and the
  // divide-by-zero result is discarded through o_wr.
  assign w_b_safe = (w_div0 || w_ovf) ? 32'd1 : i_b;

  assign w_sa    = {{32{i_a[31]}}, i_a};
  assign w_sb    = {{32{i_b[31]}}, i_b};
  assign w_sprod = w_sa * w_sb;
  assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

  assign w_squot = $signed(i_a) / $signed(w_b_safe);
  assign w_srem  = $signed(i_a) % $signed(w_b_safe);
  assign w_uquot = i_a / w_b_safe;
  assign w_urem  = i_a % w_b_safe;

  always_comb begin
    o_result = '0;
    o_wr     = 1'b0;
    case (i_op)
      MD_MULT: begin
        o_result = w_sprod;
        o_wr     = 1'b1;
      end
      MD_MULTU: begin
        o_result = w_uprod;
        o_wr     = 1'b1;
      end
      MD_DIV: begin
        o_result = {w_srem, w_squot};
        o_wr     = ~w_div0;
      end
      MD_DIVU: begin
        o_result = {w_urem, w_uquot};
        o_wr     = ~w_div0;
      end
      default: begin
        o_result = '0;
        o_wr     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: EX-stage multi-cycle multiply/divide unit with HI/LO registers.
//   clk       rising-edge clock
//   reset     asynchronous active-high reset, clears all state
//   req       EX flush; blocks a launch or MT* write in the same cycle
//   start     EX holds an md instruction (qualified by op)
//   op        MD_* opcode
//   A, B      forwarded rs/rt operands
//   busy      operation in flight
//   stallReq  busy, or a multi-cycle op is being launched this cycle
//   hi, lo    HI/LO registers
//   mdOut     MFHI/MFLO read value (combinational, 0 for other ops)
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stallReq,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdOut
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  md_state_e   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]  r_op, w_op_nxt;
  logic [31:0] r_a, w_a_nxt;
  logic [31:0] r_b, w_b_nxt;
  logic [31:0] r_hi, w_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;

  logic        w_accept;
  logic [63:0] w_core_result;
  logic        w_core_wr;

  md_core u_core (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_core_result),
    .o_wr     (w_core_wr)
  );

  assign w_accept = start && !req && (r_state == ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (md_is_long(op)) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = md_is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            w_op_nxt    = op;
            w_a_nxt     = A;
            w_b_nxt     = B;
          end else if (op == MD_MTHI) begin
            w_hi_nxt = A;
          end else if (op == MD_MTLO) begin
            w_lo_nxt = A;
          end
        end
      end
      ST_RUN: begin
        // Starts are ignored here; the in-flight op completes even under req.
        if (r_cnt == CW'(1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          if (w_core_wr) begin
            w_hi_nxt = w_core_result[63:32];
            w_lo_nxt = w_core_result[31:0];
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy     = (r_state == ST_RUN);
  assign stallReq = busy || (start && !req && md_is_long(op));
  assign hi       = r_hi;
  assign lo       = r_lo;

  always_comb begin
    mdOut = '0;
    case (op)
      MD_MFHI: mdOut = r_hi;
      MD_MFLO: mdOut = r_lo;
      default: mdOut = '0;
    endcase
  end

  a_no_start_while_busy: assert property (@(posedge clk) disable iff (reset)
    !(busy && start && !req && (md_is_long(op) || md_is_mt(op))))
    else $warning("mdu_unit: md instruction issued while busy was ignored");

endmodule

// File: tb/tb_mdu_unit.sv
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        stallReq;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdOut;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .stallReq (stallReq),
    .hi       (hi),
    .lo       (lo),
    .mdOut    (mdOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  int unsigned run    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a multi-cycle result is presented when busy drops.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      run = 0;
    end else if (busy) begin
      run++;
    end else if (run != 0) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow: completion seen with no expected entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_hi", 64'(hi), 64'(e.hi));
        chk("result_lo", 64'(lo), 64'(e.lo));
        chk("busy_cycles", 64'(run), 64'(e.cyc));
      end
      run = 0;
    end
  end

  // Reference model: {hi,lo} after the operation, from plain integer arithmetic.
  task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int              sa;
    int              sb_;
    longint          sp;
    longint unsigned up;
    sa  = a;
    sb_ = b;
    case (o)
      MD_MULT: begin
        sp = longint'(sa) * longint'(sb_);
        m_hi = sp[63:32]; m_lo = sp[31:0];
        sb.push_back('{m_hi, m_lo, MC});
      end
      MD_MULTU: begin
        up = longint'(a) * longint'(b);
        m_hi = up[63:32]; m_lo = up[31:0];
        sb.push_back('{m_hi, m_lo, MC});
      end
      MD_DIV: begin
        if (b != 0) begin
          sp = longint'(sa) / longint'(sb_);
          m_lo = sp[31:0];
          sp = longint'(sa) % longint'(sb_);
          m_hi = sp[31:0];
        end
        sb.push_back('{m_hi, m_lo, DC});
      end
      MD_DIVU: begin
        if (b != 0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
        sb.push_back('{m_hi, m_lo, DC});
      end
      MD_MTHI: m_hi = a;
      MD_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles, required 0", busy, n);
    end
  endtask

  // Called at posedge+1 with the unit idle; returns at the next posedge+1.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic r);
    logic lng;
    lng = (o == MD_MULT) || (o == MD_MULTU) || (o == MD_DIV) || (o == MD_DIVU);
    start = 1'b1; op = o; A = a; B = b; req = r;
    #1;
    chk("stallReq_launch", 64'(stallReq), 64'(lng && !r));
    if (!r) model(o, a, b);
    @(posedge clk); #1;
    start = 1'b0; req = 1'b0; op = MD_NONE;
    if (r) begin
      chk("req_busy", 64'(busy), 64'd0);
      chk("req_hi", 64'(hi), 64'(m_hi));
      chk("req_lo", 64'(lo), 64'(m_lo));
    end else if (lng) begin
      chk("busy_after_launch", 64'(busy), 64'd1);
      chk("stallReq_busy", 64'(stallReq), 64'd1);
    end else if (o == MD_MTHI || o == MD_MTLO) begin
      chk("mt_busy", 64'(busy), 64'd0);
      chk("mt_hi", 64'(hi), 64'(m_hi));
      chk("mt_lo", 64'(lo), 64'(m_lo));
    end
  endtask

  task automatic check_mdout();
    op = MD_MFHI; #1;
    chk("mdOut_mfhi", 64'(mdOut), 64'(m_hi));
    op = MD_MFLO; #1;
    chk("mdOut_mflo", 64'(mdOut), 64'(m_lo));
    op = MD_NONE; #1;
    chk("mdOut_none", 64'(mdOut), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ops[6];
    logic [3:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic        r;
    ops[0] = MD_MULT; ops[1] = MD_MULTU; ops[2] = MD_DIV;
    ops[3] = MD_DIVU; ops[4] = MD_MTHI;  ops[5] = MD_MTLO;

    reset = 1'b1; req = 1'b0; start = 1'b0; op = MD_NONE; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_stallReq", 64'(stallReq), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle();
    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle();
    check_mdout();
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle();
    do_op(MD_DIVU, 32'd7, 32'd0, 1'b0);
    wait_idle();
    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    check_mdout();

    // Flushed launch, then req arriving while a DIV is in flight.
    do_op(MD_MULT, 32'd9, 32'd9, 1'b1);
    do_op(MD_DIV, 32'd100, 32'd7, 1'b0);
    @(posedge clk); #1;
    req = 1'b1; start = 1'b1; op = MD_MULT; A = 32'd1; B = 32'd1;
    @(posedge clk); #1;
    req = 1'b0; start = 1'b0; op = MD_NONE;
    wait_idle();

    // MTLO, then MTHI while busy must be ignored.
    do_op(MD_MTLO, 32'h0000_1234, 32'd0, 1'b0);
    do_op(MD_MULT, 32'd6, 32'd7, 1'b0);
    start = 1'b1; op = MD_MTHI; A = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; op = MD_NONE;
    wait_idle();
    check_mdout();

    // Asynchronous reset in the third cycle of a MULT.
    do_op(MD_MULT, 32'd123, 32'd456, 1'b0);
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("async_reset_busy", 64'(busy), 64'd0);
    chk("async_reset_hi", 64'(hi), 64'd0);
    chk("async_reset_lo", 64'(lo), 64'd0);
    m_hi = '0; m_lo = '0;
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    do_op(MD_MULT, 32'h0001_0000, 32'h0001_0000, 1'b0);
    wait_idle();

    // Randomized operations against the model.
    for (int i = 0; i < 60; i++) begin
      o = ops[$urandom_range(0, 5)];
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 9) == 0) b = $urandom_range(0, 15);
      if ($urandom_range(0, 15) == 0) begin
        a = 32'h8000_0000; b = 32'hFFFF_FFFF;
      end
      r = ($urandom_range(0, 7) == 0);
      do_op(o, a, b, r);
      wait_idle();
      if ((i % 10) == 0) check_mdout();
    end

    wait_idle();
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
